host_clause_loader: RTL

- Receiving end of the host literal-load stream (valid/literal/clause_end/ready) that the host or bench drives into satswarm_top before host_start.
- Packs signed DIMACS literals into a literal store and a per-clause descriptor table (start pointer, length).
- Tracks the highest variable index and the clause/literal counts, and flags malformed or oversized input.
- Sits between the top-level host port and the per-core clause memories. The solver reads the tables only after load_done.

---
 rtl/host_clause_loader_pkg.sv | 64 ++++++
 rtl/host_clause_loader_if.sv | 12 +
 rtl/host_clause_loader_lit_validator.sv | 27 ++
 rtl/host_clause_loader.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/host_clause_loader_pkg.sv
// Shared types for the host literal-load path: literal encoding, clause descriptors,
// error codes and loader FSM states, plus the literal check/encode helper.
// Pure declarations; no ports, no latency, no backpressure.
// Widths below describe the default build (128 vars / 128 clauses / 512 literals / len 16).
package satswarm_load_pkg;

    localparam int DEF_MAX_VARS       = 128;
    localparam int DEF_MAX_CLAUSES    = 128;
    localparam int DEF_MAX_LITS       = 512;
    localparam int DEF_MAX_CLAUSE_LEN = 16;

    localparam int DEF_VAR_W     = $clog2(DEF_MAX_VARS + 1);
    localparam int DEF_LIT_PTR_W = $clog2(DEF_MAX_LITS);
    localparam int DEF_LEN_W     = $clog2(DEF_MAX_CLAUSE_LEN + 1);

    // Literal as stored: sign (1 = negated) above the variable index.
    typedef struct packed {
        logic                 neg;
        logic [DEF_VAR_W-1:0] var_idx;
    } lit_enc_t;

    // Clause descriptor: first literal's store address and literal count.
    typedef struct packed {
        logic [DEF_LIT_PTR_W-1:0] start_ptr;
        logic [DEF_LEN_W-1:0]     len;
    } clause_desc_t;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_ZERO_LIT  = 3'd1,
        ERR_VAR_RANGE = 3'd2,
        ERR_LIT_OVF   = 3'd3,
        ERR_CLS_OVF   = 3'd4,
        ERR_CLS_LONG  = 3'd5,
        ERR_START_MID = 3'd6
    } load_err_e;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DONE  = 2'd1,
        ST_ERROR = 2'd2
    } load_state_e;

    // Result of checking one signed DIMACS literal.
    typedef struct packed {
        logic        zero;
        logic        out_of_range;
        logic        neg;
        logic [31:0] mag;
    } lit_chk_t;

    // Magnitude is taken in unsigned arithmetic, so -2^31 yields 2^31 and
    // is therefore always reported out of range.
    function automatic lit_chk_t encode_lit(input logic signed [31:0] lit,
                                            input logic [31:0]        max_vars);
        lit_chk_t r;
        r.zero         = (lit == 32'sd0);
        r.neg          = lit[31];
        r.mag          = lit[31] ? (~lit + 32'd1) : lit;
        r.out_of_range = (r.mag > max_vars);
        return r;
    endfunction

endpackage

// File: rtl/host_clause_loader_if.sv
// Host literal-load stream: one signed literal per beat, clause_end marks the last
// literal of a clause. Transfer happens when valid && ready at a clock edge.
// Ports: master (host) drives valid/literal/clause_end; slave (loader) drives ready.
interface host_clause_loader_if;
    logic               valid;
    logic signed [31:0] literal;
    logic               clause_end;
    logic               ready;

    modport master (output valid, output literal, output clause_end, input ready);
    modport slave  (input valid, input literal, input clause_end, output ready);
endinterface

// File: rtl/host_clause_loader_lit_validator.sv
// Combinational zero/range check and {sign, var} encode of one DIMACS literal.
// Latency: zero cycles. No backpressure.
// Ports: literal in; zero_err, range_err, enc out. Also used by clause-memory debug checks.
module lit_validator
    import satswarm_load_pkg::*;
#(
    parameter  int MAX_VARS = 128,
    localparam int VAR_W    = $clog2(MAX_VARS + 1)
) (
    input  logic signed [31:0] literal,
    output logic               zero_err,
    output logic               range_err,
    output logic [VAR_W:0]     enc
);

    lit_chk_t chk;

    always_comb begin
        chk       = encode_lit(literal, 32'(MAX_VARS));
        zero_err  = chk.zero;
        // Bits above VAR_W are dropped from enc; flagging them here guarantees a
        // truncated encoding can never alias a legal variable.
        range_err = chk.out_of_range | (|chk.mag[31:VAR_W]);
        enc       = {chk.neg, chk.mag[VAR_W-1:0]};
    end

endmodule

// File: rtl/host_clause_loader.sv
// Packs host literals into a literal store and a clause descriptor table; tracks counts,
// max variable, and flags malformed input. Writes appear one cycle after the accepted beat.
// Backpressure: ready drops when the store or table fills, or once DONE/ERROR is reached.
// Ports: clk, rst (async active-high), host_load (slave stream), host_start, lit_wr_*,
// cls_wr_*, num_clauses, num_lits, max_var, load_done, load_error, error_code.
// Optional HOST_LOADER_STATS_EN adds unit_clauses and max_clause_len outputs.
module host_clause_loader
    import satswarm_load_pkg::*;
#(
    parameter  int MAX_VARS       = 128,
    parameter  int MAX_CLAUSES    = 128,
    parameter  int MAX_LITS       = 512,
    parameter  int MAX_CLAUSE_LEN = 16,
    localparam int VAR_W          = $clog2(MAX_VARS + 1),
    localparam int LIT_PTR_W      = $clog2(MAX_LITS),
    localparam int CLS_PTR_W      = $clog2(MAX_CLAUSES),
    localparam int LEN_W          = $clog2(MAX_CLAUSE_LEN + 1),
    localparam int NLIT_W         = $clog2(MAX_LITS + 1),
    localparam int NCLS_W         = $clog2(MAX_CLAUSES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    host_clause_loader_if.slave        host_load,
    input  logic                       host_start,
    output logic                       lit_wr_en,
    output logic [LIT_PTR_W-1:0]       lit_wr_addr,
    output logic [VAR_W:0]             lit_wr_data,
    output logic                       cls_wr_en,
    output logic [CLS_PTR_W-1:0]       cls_wr_addr,
    output logic [LIT_PTR_W+LEN_W-1:0] cls_wr_data,
    output logic [NCLS_W-1:0]          num_clauses,
    output logic [NLIT_W-1:0]          num_lits,
    output logic [VAR_W-1:0]           max_var,
    output logic                       load_done,
    output logic                       load_error,
    output logic [2:0]                 error_code
`ifdef HOST_LOADER_STATS_EN
    ,
    output logic [NCLS_W-1:0]          unit_clauses,
    output logic [LEN_W-1:0]           max_clause_len
`endif
);

    localparam logic [NLIT_W-1:0] LITS_FULL = NLIT_W'(MAX_LITS);
    localparam logic [NCLS_W-1:0] CLS_FULL  = NCLS_W'(MAX_CLAUSES);
    localparam logic [LEN_W-1:0]  LEN_FULL  = LEN_W'(MAX_CLAUSE_LEN);

    load_state_e          state;
    logic                 ready_q;
    logic [LEN_W-1:0]     clause_len;   // literals already taken for the open clause
    logic [LIT_PTR_W-1:0] start_ptr;    // store address of the open clause's first literal

    logic                 zero_err;
    logic                 range_err;
    logic [VAR_W:0]       enc;

    logic                 accept;
    logic                 take;
    logic                 commit;
    load_err_e            beat_err;
    logic [NLIT_W-1:0]    lits_nxt;
    logic [NCLS_W-1:0]    cls_nxt;
    logic [LEN_W-1:0]     len_inc;
    logic [LEN_W-1:0]     len_nxt;

    assign host_load.ready = ready_q;

    lit_validator #(
        .MAX_VARS (MAX_VARS)
    ) u_lit_validator (
        .literal   (host_load.literal),
        .zero_err  (zero_err),
        .range_err (range_err),
        .enc       (enc)
    );

    always_comb begin
        accept   = host_load.valid & ready_q;
        beat_err = ERR_NONE;
        if (zero_err)                    beat_err = ERR_ZERO_LIT;
        else if (range_err)              beat_err = ERR_VAR_RANGE;
        else if (num_lits >= LITS_FULL)  beat_err = ERR_LIT_OVF;
        else if (num_clauses >= CLS_FULL) beat_err = ERR_CLS_OVF;
        else if (clause_len >= LEN_FULL) beat_err = ERR_CLS_LONG;

        take     = accept & (beat_err == ERR_NONE);
        commit   = take & host_load.clause_end;
        lits_nxt = num_lits + NLIT_W'(take);
        cls_nxt  = num_clauses + NCLS_W'(commit);
        len_inc  = clause_len + LEN_W'(1);
        len_nxt  = commit ? '0 : (take ? len_inc : clause_len);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_LOAD;
            ready_q        <= 1'b0;
            clause_len     <= '0;
            start_ptr      <= '0;
            lit_wr_en      <= 1'b0;
            lit_wr_addr    <= '0;
            lit_wr_data    <= '0;
            cls_wr_en      <= 1'b0;
            cls_wr_addr    <= '0;
            cls_wr_data    <= '0;
            num_clauses    <= '0;
            num_lits       <= '0;
            max_var        <= '0;
            load_done      <= 1'b0;
            load_error     <= 1'b0;
            error_code     <= ERR_NONE;
`ifdef HOST_LOADER_STATS_EN
            unit_clauses   <= '0;
            max_clause_len <= '0;
`endif
        end else begin
            lit_wr_en <= 1'b0;
            cls_wr_en <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (accept && beat_err != ERR_NONE) begin
                        // A bad beat writes nothing and freezes the tables.
                        state      <= ST_ERROR;
                        ready_q    <= 1'b0;
                        load_error <= 1'b1;
                        error_code <= beat_err;
                    end else begin
                        if (take) begin
                            lit_wr_en   <= 1'b1;
                            lit_wr_addr <= num_lits[LIT_PTR_W-1:0];
                            lit_wr_data <= enc;
                            num_lits    <= lits_nxt;
                            clause_len  <= len_nxt;
                            if (enc[VAR_W-1:0] > max_var)
                                max_var <= enc[VAR_W-1:0];
                        end
                        if (commit) begin
                            cls_wr_en   <= 1'b1;
                            cls_wr_addr <= num_clauses[CLS_PTR_W-1:0];
                            cls_wr_data <= {start_ptr, len_inc};
                            num_clauses <= cls_nxt;
                            // Wraps to 0 only when the store is full, after which
                            // no further clause can start.
                            start_ptr   <= lits_nxt[LIT_PTR_W-1:0];
`ifdef HOST_LOADER_STATS_EN
                            if (clause_len == '0)
                                unit_clauses <= unit_clauses + NCLS_W'(1);
                            if (len_inc > max_clause_len)
                                max_clause_len <= len_inc;
`endif
                        end
                        // Judged on the post-beat length so a clause closed on the
                        // same edge as host_start still counts as complete.
                        if (host_start) begin
                            ready_q <= 1'b0;
                            if (len_nxt != '0) begin
                                state      <= ST_ERROR;
                                load_error <= 1'b1;
                                error_code <= ERR_START_MID;
                            end else begin
                                state     <= ST_DONE;
                                load_done <= 1'b1;
                            end
                        end else begin
                            // A full store with an open clause leaves the host stalled;
                            // only rst recovers from that.
                            ready_q <= (lits_nxt < LITS_FULL) && (cls_nxt < CLS_FULL);
                        end
                    end
                end
                default: begin
                    // DONE and ERROR hold until rst; host_start is ignored here.
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
